regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing one register-file write port between the ALU and load paths.
// Define WB_MEM_PRIORITY_EN for fixed mem-over-ALU priority; the default build is round-robin.

module regfile_wb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic [4:0]  i_rd,
    input  logic [63:0] i_data,
    input  logic        i_pop,
    output logic        o_full,
    output logic        o_empty,
    output logic [4:0]  o_rd,
    output logic [63:0] o_data,
    output logic [31:0] o_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_rd   [DEPTH];
    logic [63:0]   r_data [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_rd[r_wp]   <= i_rd;
                r_data[r_wp] <= i_data;
                r_wp         <= r_wp + AW'(1);
            end
            if (i_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_rd    = r_rd[r_rp];
    assign o_data  = r_data[r_rp];

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [AW-1:0] v_off;
        o_busy = '0;
        v_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_off = AW'(i) - r_rp;
            if ({1'b0, v_off} < r_cnt) begin
                o_busy[r_rd[i]] = 1'b1;
            end
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [63:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [63:0] mem_data,
    output logic [4:0]  RW,
    output logic [63:0] BusW,
    output logic        RegWr,
    output logic [31:0] busy_mask
);
    // Handshake: a producer transfers on a posedge where valid && ready; ready is
    // !Reset && FIFO not full, never looks at valid, and there is no pass-through when full.
    logic        w_alu_full, w_alu_empty, w_alu_push;
    logic        w_mem_full, w_mem_empty, w_mem_push;
    logic [4:0]  w_alu_head_rd, w_mem_head_rd;
    logic [63:0] w_alu_head_data, w_mem_head_data;
    logic [31:0] w_alu_busy, w_mem_busy, w_out_busy;
    logic        w_grant_alu, w_grant_mem;

    assign alu_ready  = !Reset && !w_alu_full;
    assign mem_ready  = !Reset && !w_mem_full;
    // Writes to XZR complete the handshake but are dropped here.
    assign w_alu_push = alu_valid && alu_ready && (alu_rd != 5'd31);
    assign w_mem_push = mem_valid && mem_ready && (mem_rd != 5'd31);

    regfile_wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_push  (w_alu_push),
        .i_rd    (alu_rd),
        .i_data  (alu_data),
        .i_pop   (w_grant_alu),
        .o_full  (w_alu_full),
        .o_empty (w_alu_empty),
        .o_rd    (w_alu_head_rd),
        .o_data  (w_alu_head_data),
        .o_busy  (w_alu_busy)
    );

    regfile_wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_push  (w_mem_push),
        .i_rd    (mem_rd),
        .i_data  (mem_data),
        .i_pop   (w_grant_mem),
        .o_full  (w_mem_full),
        .o_empty (w_mem_empty),
        .o_rd    (w_mem_head_rd),
        .o_data  (w_mem_head_data),
        .o_busy  (w_mem_busy)
    );

`ifdef WB_MEM_PRIORITY_EN
    always_comb begin
        w_grant_mem = !w_mem_empty;
        w_grant_alu = !w_alu_empty && w_mem_empty;
    end
`else
    // r_last_mem = 1 when the most recent grant went to the load path.
    logic r_last_mem;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last_mem <= 1'b1;
        end else if (w_grant_alu) begin
            r_last_mem <= 1'b0;
        end else if (w_grant_mem) begin
            r_last_mem <= 1'b1;
        end
    end

    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (!w_alu_empty && !w_mem_empty) begin
            w_grant_alu = r_last_mem;
            w_grant_mem = !r_last_mem;
        end else begin
            w_grant_alu = !w_alu_empty;
            w_grant_mem = !w_mem_empty;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWr <= 1'b0;
            RW    <= '0;
            BusW  <= '0;
        end else if (w_grant_alu) begin
            RegWr <= 1'b1;
            RW    <= w_alu_head_rd;
            BusW  <= w_alu_head_data;
        end else if (w_grant_mem) begin
            RegWr <= 1'b1;
            RW    <= w_mem_head_rd;
            BusW  <= w_mem_head_data;
        end else begin
            RegWr <= 1'b0;
        end
    end

    assign w_out_busy = RegWr ? (32'd1 << RW) : 32'd0;
    assign busy_mask  = (w_alu_busy | w_mem_busy | w_out_busy) & 32'h7FFF_FFFF;
endmodule
